fifo_frame_reader: RTL

Read-domain consumer for the async FIFO. It drains samples through the FIFO's rd_en/empty/rd_data port and presents them as a valid/ready stream to the FFT. The stream is framed into FRAME_LEN-sample blocks with first/last markers. It never reads the FIFO while empty, absorbs the FIFO's 1-cycle registered read latency, and stops only on frame boundaries.

---
 rtl/fifo_reader_pkg.sv | 17 +
 rtl/fifo_frame_reader_skid.sv | 61 ++++++
 rtl/fifo_frame_reader.sv | 113 +++++++++++
 3 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO frame reader.
// Imported by the reader top and its output buffer.
package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } reader_state_t;

    localparam int BUF_DEPTH = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_frame_reader_skid.sv
// Two-entry in-order output buffer between the FIFO read pipe
// and the valid/ready stream; entry 0 is always the head.
module stream_skid_buffer
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [1:0]            count
);

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] ent0;
    logic [DATA_WIDTH-1:0] ent1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0  <= '0;
            ent1  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        ent0 <= push_data;
                    end else begin
                        ent1 <= push_data;
                    end
                    if (count != FULL) begin
                        count <= count + 2'd1;
                    end
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                // Push and pop together: count holds, head advances.
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head_data  = ent0;
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/fifo_frame_reader.sv
// Drains the async FIFO read port into a framed valid/ready
// stream, stopping only on frame boundaries.
module fifo_frame_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAME_LEN  = 64,
    parameter int IDX_W      = idx_width(FRAME_LEN)
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_first,
    output logic                  out_last,
    output logic [IDX_W-1:0]      out_index,
    output logic [15:0]           frame_count,
    output logic                  busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [2:0]       CREDITS  = 3'(BUF_DEPTH);

    reader_state_t    state;
    reader_state_t    state_nxt;
    logic             issue_allowed;
    logic             inflight;
    logic             pop;
    logic [1:0]       buf_count;
    logic [2:0]       occupancy;
    logic [IDX_W-1:0] issue_idx;

    assign pop = out_valid && out_ready;

    // Slots already committed, crediting the beat leaving this cycle.
    assign occupancy = {1'b0, buf_count} + {2'b00, inflight}
                     - {2'b00, pop};

    assign fifo_rd_en = !rd_rst && !fifo_empty && issue_allowed
                     && (occupancy < CREDITS);

    always_comb begin
        state_nxt     = state;
        issue_allowed = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = STREAM;
            end
            STREAM: begin
                issue_allowed = 1'b1;
                if (!enable) state_nxt = DRAIN;
            end
            DRAIN: begin
                issue_allowed = (issue_idx != '0);
                if (enable) begin
                    state_nxt = STREAM;
                end else if (issue_idx == '0 && !inflight
                             && buf_count == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state       <= IDLE;
            inflight    <= 1'b0;
            issue_idx   <= '0;
            out_index   <= '0;
            frame_count <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                issue_idx <= (issue_idx == LAST_IDX) ? '0
                           : issue_idx + 1'b1;
            end
            if (pop) begin
                out_index <= (out_index == LAST_IDX) ? '0
                           : out_index + 1'b1;
                if (out_index == LAST_IDX) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (rd_clk),
        .rst        (rd_rst),
        .push       (inflight),
        .push_data  (fifo_rd_data),
        .pop        (pop),
        .head_data  (out_data),
        .head_valid (out_valid),
        .count      (buf_count)
    );

    assign out_first = out_valid && (out_index == '0);
    assign out_last  = out_valid && (out_index == LAST_IDX);
    assign busy      = (state != IDLE) || (buf_count != 2'd0)
                    || inflight;

endmodule
